// File: rtl/counter_pkg.sv
// Shared configuration for the free-running counter.
// Holds the default width and the legal width range used by the top level.
// No types are exported; the counter has a single integer parameter.
package counter_pkg;

  // Default counter width and the legal range for the Size parameter.
  localparam int COUNTER_DEFAULT_SIZE = 5;
  localparam int COUNTER_MIN_SIZE     = 1;
  localparam int COUNTER_MAX_SIZE     = 32;

endpackage : counter_pkg

// File: rtl/counter.sv
// Free-running Size-bit binary up-counter, modulo 2^Size, synchronous active-high reset.
// Latency: the updated value is visible right after each rising edge (count is a register).
// Backpressure: none; leaf block with no handshake, counts on every non-reset edge.
//
// Ports:
//   clock  - system clock, all state changes on the rising edge
//   reset  - synchronous active-high reset, takes priority over counting and wrap
//   count  - current counter value, driven straight from count_q
module counter
  import counter_pkg::*;
#(
  parameter int Size = COUNTER_DEFAULT_SIZE
) (
  input  logic            clock,
  input  logic            reset,
  output logic [Size-1:0] count
);

  // Reject out-of-range widths at elaboration time.
  if (Size < COUNTER_MIN_SIZE) begin : g_size_too_small
    $fatal(1, "counter: Size must be at least 1");
  end
  if (Size > COUNTER_MAX_SIZE) begin : g_size_too_large
    $fatal(1, "counter: Size must not exceed 32");
  end

  logic [Size-1:0] count_q;

  // Reset wins over the increment, so a reset edge at all-ones yields 0, not a
  // wrap followed by an increment. The add truncates to Size bits, which gives
  // the 2^Size-1 -> 0 wrap for free with no extra cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + Size'(1);
    end
  end

  assign count = count_q;

endmodule : counter

// File: tb/tb_counter.sv
module tb_counter;

  logic       clock;
  logic       rst5;
  logic       rst1;
  logic       rst8;
  logic [4:0] count5;
  logic [0:0] count1;
  logic [7:0] count8;

  int tests;
  int errors;

  counter #(.Size(5)) dut5 (.clock(clock), .reset(rst5), .count(count5));
  counter #(.Size(1)) dut1 (.clock(clock), .reset(rst1), .count(count1));
  counter #(.Size(8)) dut8 (.clock(clock), .reset(rst8), .count(count8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk5(input string name, input logic [4:0] exp);
    tests++;
    if (count5 !== exp) begin
      errors++;
      $display("FAIL %s: count=%0d expected=%0d", name, count5, exp);
    end
  endtask

  // Reset for one edge then release, leaving count5 at 0 after the sample.
  task automatic reset5();
    rst5 = 1'b1;
    tick();
    rst5 = 1'b0;
  endtask

  task automatic test_reset();
    rst5 = 1'b1;
    tick(); chk5("reset_edge1", 5'd0);
    tick(); chk5("reset_edge2", 5'd0);
    rst5 = 1'b0;
    tick(); chk5("release_1", 5'd1);
    tick(); chk5("release_2", 5'd2);
    tick(); chk5("release_3", 5'd3);
  endtask

  task automatic test_wrap();
    reset5();
    chk5("wrap_start", 5'd0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk5($sformatf("wrap_count_%0d", i), 5'(i));
    end
    tick(); chk5("wrap_to_0", 5'd0);
    tick(); chk5("wrap_then_1", 5'd1);
  endtask

  task automatic test_reset_mid();
    reset5();
    repeat (17) tick();
    chk5("mid_at_17", 5'd17);
    rst5 = 1'b1;
    tick(); chk5("mid_reset_edge", 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk5($sformatf("mid_hold_%0d", i), 5'd0);
    end
    rst5 = 1'b0;
    tick(); chk5("mid_release", 5'd1);
  endtask

  task automatic test_reset_at_max();
    reset5();
    repeat (31) tick();
    chk5("max_at_31", 5'd31);
    rst5 = 1'b1;
    tick(); chk5("max_reset_priority", 5'd0);
    rst5 = 1'b0;
    tick(); chk5("max_release", 5'd1);
  endtask

  task automatic test_sync_reset_glitch();
    reset5();
    repeat (5) tick();
    chk5("glitch_at_5", 5'd5);
    // Pulse reset entirely between edges; it must never be sampled.
    #2 rst5 = 1'b1;
    #2 rst5 = 1'b0;
    tick(); chk5("glitch_1", 5'd6);
    #1 rst5 = 1'b1;
    #3 rst5 = 1'b0;
    tick(); chk5("glitch_2", 5'd7);
  endtask

  task automatic test_size1();
    rst1 = 1'b1;
    tick();
    tests++;
    if (count1 !== 1'b0) begin
      errors++;
      $display("FAIL size1_reset: count=%0d expected=0", count1);
    end
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic exp1;
      exp1 = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      tests++;
      if (count1 !== exp1) begin
        errors++;
        $display("FAIL size1_toggle_%0d: count=%0d expected=%0d", i, count1, exp1);
      end
    end
  endtask

  task automatic test_size8();
    rst8 = 1'b1;
    tick();
    tests++;
    if (count8 !== 8'd0) begin
      errors++;
      $display("FAIL size8_reset: count=%0d expected=0", count8);
    end
    rst8 = 1'b0;
    repeat (255) tick();
    tests++;
    if (count8 !== 8'd255) begin
      errors++;
      $display("FAIL size8_at_255: count=%0d expected=255", count8);
    end
    tick();
    tests++;
    if (count8 !== 8'd0) begin
      errors++;
      $display("FAIL size8_wrap: count=%0d expected=0", count8);
    end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    rst5   = 1'b1;
    rst1   = 1'b1;
    rst8   = 1'b1;
    #1;
    test_reset();
    test_wrap();
    test_reset_mid();
    test_reset_at_max();
    test_sync_reset_glitch();
    test_size1();
    test_size8();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_counter
